// File: rtl/alu_pkg.sv
// Shared types for the add/subtract pipeline: op encodings and status flags.
package alu_pkg;

  localparam logic [1:0] ENC_ADD  = 2'b00;
  localparam logic [1:0] ENC_SUB  = 2'b01;
  localparam logic [1:0] ENC_ADDC = 2'b10;
  localparam logic [1:0] ENC_SUBB = 2'b11;

  typedef enum logic [1:0] {
    OP_ADD  = ENC_ADD,
    OP_SUB  = ENC_SUB,
    OP_ADDC = ENC_ADDC,
    OP_SUBB = ENC_SUBB
  } op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  function automatic logic is_sub(input op_e op);
    return (op == OP_SUB) || (op == OP_SUBB);
  endfunction

  function automatic logic is_chain(input op_e op);
    return (op == OP_ADDC) || (op == OP_SUBB);
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// Generic valid/ready register slice; accepts new data when empty or
// when its current contents leave in the same cycle.
module alu_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe_hs.sv
// Two-stage add/sub unit with valid/ready handshake and a carry chain register.
// Optional ALU_SAT_EN: unsigned saturation of the result on carry/borrow.
module alu_pipe_hs
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output flags_t           out_flags
);

  localparam int S1W = 2 + 2*WIDTH;
  localparam int S2W = WIDTH + 4;

  logic           s1_valid, s2_in_ready, s2_load, carry_q;
  logic [S1W-1:0] s1_data;
  logic [S2W-1:0] s2_data;

  alu_pipe_stage #(.W(S1W)) u_s1 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, in_a, in_b}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  op_e              op;
  logic [WIDTH-1:0] a, b, r_raw, r;
  logic [WIDTH:0]   cin_w, wide;
  logic             sub, c, ovf;
  flags_t           flags;

  assign op    = op_e'(s1_data[S1W-1 -: 2]);
  assign a     = s1_data[2*WIDTH-1:WIDTH];
  assign b     = s1_data[WIDTH-1:0];
  assign sub   = is_sub(op);
  assign cin_w = {{WIDTH{1'b0}}, is_chain(op) & carry_q};

  // One extra bit captures carry out on add and borrow on subtract.
  assign wide  = sub ? ({1'b0, a} - {1'b0, b} - cin_w)
                     : ({1'b0, a} + {1'b0, b} + cin_w);
  assign c     = wide[WIDTH];
  assign r_raw = wide[WIDTH-1:0];
  assign ovf   = sub ? ((a[WIDTH-1] ^ b[WIDTH-1]) & (r_raw[WIDTH-1] ^ a[WIDTH-1]))
                     : (~(a[WIDTH-1] ^ b[WIDTH-1]) & (r_raw[WIDTH-1] ^ a[WIDTH-1]));

`ifdef ALU_SAT_EN
  assign r = c ? (sub ? '0 : '1) : r_raw;
`else
  assign r = r_raw;
`endif

  assign flags = '{carry: c, zero: (r == '0), neg: r[WIDTH-1], ovf: ovf};

  assign s2_load = s1_valid && s2_in_ready;

  alu_pipe_stage #(.W(S2W)) u_s2 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   ({r, flags}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_result = s2_data[S2W-1:4];
  assign out_flags  = flags_t'(s2_data[3:0]);

  // Carry is captured as ops enter S2, so chained ops always see their predecessor.
  always_ff @(posedge clock) begin
    if (reset)        carry_q <= 1'b0;
    else if (s2_load) carry_q <= c;
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Randomised and directed bench for alu_pipe_hs (WIDTH=8) with an arithmetic reference model.
module tb_alu_pipe_hs;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  op_e         in_op;
  logic [7:0]  in_a, in_b, out_result;
  flags_t      out_flags;

  always #5 clock = ~clock;

  alu_pipe_hs #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
    int         cyc;
  } res_t;

  res_t exp_q[$], rcv_q[$];
  int   tests = 0, fails = 0, cyc = 0;
  logic mcarry = 1'b0, last_acc = 1'b0;

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic res_t model(input op_e op, input int a, input int b, input logic cin,
                                 output logic cout);
    res_t e;
    int ci, s, sa, sb, sr, r;
    bit sub;
    sub = (op == OP_SUB) || (op == OP_SUBB);
    ci  = (op == OP_ADDC || op == OP_SUBB) ? int'(cin) : 0;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    if (sub) begin s = a - b - ci; sr = sa - sb - ci; cout = (s < 0); end
    else     begin s = a + b + ci; sr = sa + sb + ci; cout = (s > 255); end
    r = (s + 512) % 256;
`ifdef ALU_SAT_EN
    if (cout) r = sub ? 0 : 255;
`endif
    e.r   = 8'(r);
    e.f   = {cout, (r == 0), (r >= 128), (sr > 127 || sr < -128)};
    e.cyc = 0;
    return e;
  endfunction

  // One clock of bookkeeping: logs accepted ops into the model and drained results.
  task automatic cycle();
    res_t e, g;
    logic co;
    @(negedge clock);
    last_acc = in_valid && in_ready && !reset;
    if (out_valid && out_ready && !reset) begin
      g.r = out_result; g.f = out_flags; g.cyc = cyc;
      rcv_q.push_back(g);
    end
    if (last_acc) begin
      e = model(in_op, int'(in_a), int'(in_b), mcarry, co);
      mcarry = co; e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic send(input op_e op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (last_acc) break;
    end
    tests++;
    if (!last_acc) begin fails++; $display("FAIL send_timeout op=%0d got no accept, required accept", op); end
    in_valid = 1'b0;
  endtask

  task automatic wait_rcv(input int n);
    for (int i = 0; i < 100 && rcv_q.size() < n; i++) cycle();
    tests++;
    if (rcv_q.size() < n) begin
      fails++; $display("FAIL drain_timeout got %0d results, required %0d", rcv_q.size(), n);
    end
  endtask

  task automatic flush();
    rcv_q.delete(); exp_q.delete();
  endtask

  task automatic chk(input string name, input res_t g, input logic [7:0] r, input logic [3:0] f);
    tests++;
    if (g.r !== r || g.f !== f) begin
      fails++; $display("FAIL %s got r=%h f=%b, required r=%h f=%b", name, g.r, g.f, r, f);
    end
  endtask

  task automatic test_reset();
    res_t g;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 8'h00 || out_flags !== 4'b0) begin
      fails++; $display("FAIL reset_init got v=%b rdy=%b r=%h f=%b, required 0 1 00 0000",
                        out_valid, in_ready, out_result, out_flags);
    end
    out_ready = 1'b1;
    send(OP_ADD, 8'hFF, 8'h01);
    wait_rcv(1);
    out_ready = 1'b0;
    send(OP_ADD, 8'hFF, 8'h01);
    send(OP_ADD, 8'h10, 8'h20);
    cycle();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    flush(); mcarry = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_flags !== 4'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid got v=%b f=%b rdy=%b, required 0 0000 1",
                        out_valid, out_flags, in_ready);
    end
    out_ready = 1'b1;
    send(OP_ADDC, 8'h01, 8'h01);
    wait_rcv(1);
    if (rcv_q.size() > 0) begin g = rcv_q.pop_front(); chk("reset_carry0", g, 8'h02, 4'b0000); end
    flush();
  endtask

  task automatic test_add();
    res_t g, e;
    out_ready = 1'b1;
    send(OP_ADD, 8'hF0, 8'h20);
    wait_rcv(1);
    if (rcv_q.size() > 0 && exp_q.size() > 0) begin
      g = rcv_q.pop_front(); e = exp_q.pop_front();
`ifdef ALU_SAT_EN
      chk("add_f0_20", g, 8'hFF, 4'b1010);
`else
      chk("add_f0_20", g, 8'h10, 4'b1000);
`endif
      tests++;
      if (g.cyc - e.cyc !== 2) begin
        fails++; $display("FAIL add_latency got %0d cycles, required 2", g.cyc - e.cyc);
      end
    end
    flush();
  endtask

  task automatic test_sub();
    res_t g;
    out_ready = 1'b1;
    send(OP_SUB, 8'h05, 8'h07);
    send(OP_SUB, 8'h80, 8'h01);
    wait_rcv(2);
    if (rcv_q.size() >= 2) begin
      g = rcv_q.pop_front();
`ifdef ALU_SAT_EN
      chk("sub_05_07", g, 8'h00, 4'b1100);
`else
      chk("sub_05_07", g, 8'hFE, 4'b1010);
`endif
      g = rcv_q.pop_front();
      chk("sub_80_01", g, 8'h7F, 4'b0001);
    end
    flush();
  endtask

  task automatic test_chain();
    res_t g;
    out_ready = 1'b1;
    send(OP_ADD, 8'hFF, 8'h01);
    send(OP_ADDC, 8'h12, 8'h34);
    wait_rcv(2);
    if (rcv_q.size() >= 2) begin
      g = rcv_q.pop_front();
`ifdef ALU_SAT_EN
      chk("chain_lo", g, 8'hFF, 4'b1010);
`else
      chk("chain_lo", g, 8'h00, 4'b1100);
`endif
      g = rcv_q.pop_front();
      chk("chain_hi", g, 8'h47, 4'b0000);
    end
    flush();
  endtask

  task automatic test_boundary();
    res_t g;
    out_ready = 1'b1;
    send(OP_SUB, 8'h00, 8'h01);
    send(OP_ADD, 8'hC0, 8'h80);
    send(OP_SUB, 8'h10, 8'h20);
    wait_rcv(3);
    if (rcv_q.size() >= 3) begin
`ifdef ALU_SAT_EN
      g = rcv_q.pop_front(); chk("bnd_00_01", g, 8'h00, 4'b1100);
      g = rcv_q.pop_front(); chk("sat_c0_80", g, 8'hFF, 4'b1011);
      g = rcv_q.pop_front(); chk("sat_10_20", g, 8'h00, 4'b1100);
`else
      g = rcv_q.pop_front(); chk("bnd_00_01", g, 8'hFF, 4'b1010);
      g = rcv_q.pop_front(); chk("wrap_c0_80", g, 8'h40, 4'b1001);
      g = rcv_q.pop_front(); chk("wrap_10_20", g, 8'hF0, 4'b1010);
`endif
    end
    flush();
  endtask

  task automatic test_backpressure();
    logic [7:0] va[4], vb[4], hold_r;
    logic [3:0] hold_f;
    op_e        vo[4];
    int         idx = 0;
    bit         seen = 0;
    res_t       g, e;
    for (int i = 0; i < 4; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom); vo[i] = op_e'($urandom_range(0, 3));
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin in_op = vo[idx]; in_a = va[idx]; in_b = vb[idx]; end
      cycle();
      if (last_acc) idx++;
      if (out_valid) begin
        if (seen) begin
          tests++;
          if (out_result !== hold_r || out_flags !== hold_f) begin
            fails++; $display("FAIL bp_hold got r=%h f=%b, required r=%h f=%b",
                              out_result, out_flags, hold_r, hold_f);
          end
        end
        seen = 1; hold_r = out_result; hold_f = out_flags;
      end
    end
    tests++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_stall got accepts=%0d rdy=%b, required 2 0", idx, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 50 && idx < 4; i++) begin
      in_valid = 1'b1; in_op = vo[idx]; in_a = va[idx]; in_b = vb[idx];
      cycle();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    wait_rcv(4);
    tests++;
    if (rcv_q.size() !== 4 || exp_q.size() !== 4) begin
      fails++; $display("FAIL bp_count got %0d/%0d, required 4/4", rcv_q.size(), exp_q.size());
    end
    while (rcv_q.size() > 0 && exp_q.size() > 0) begin
      g = rcv_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (g.r !== e.r || g.f !== e.f) begin
        fails++; $display("FAIL bp_order got r=%h f=%b, required r=%h f=%b", g.r, g.f, e.r, e.f);
      end
    end
    flush();
  endtask

  task automatic test_random();
    res_t g, e;
    for (int i = 0; i < 120; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op = op_e'($urandom_range(0, 3)); in_a = 8'($urandom); in_b = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_rcv(exp_q.size());
    tests++;
    if (rcv_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL rand_count got %0d, required %0d", rcv_q.size(), exp_q.size());
    end
    while (rcv_q.size() > 0 && exp_q.size() > 0) begin
      g = rcv_q.pop_front(); e = exp_q.pop_front();
      tests++;
      if (g.r !== e.r || g.f !== e.f) begin
        fails++; $display("FAIL rand_op got r=%h f=%b, required r=%h f=%b", g.r, g.f, e.r, e.f);
      end
    end
    flush();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = OP_ADD; in_a = '0; in_b = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_chain();
    test_boundary();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
